// File: rtl/mips32_dmem_responder.sv
// Handshaked single-port MIPS32 data memory with a fixed number of wait states per access.
// Optional feature: define DMEM_ZERO_INIT_EN to zero-sweep the whole array after every reset.
module mips32_dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

`ifdef DMEM_ZERO_INIT_EN
  typedef enum logic [1:0] {IDLE, WAIT, RESP, INIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`endif

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state;
  logic [3:0]          cnt;
  logic                lat_we;
  logic [31:0]         lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];
`ifdef DMEM_ZERO_INIT_EN
  logic [ADDR_W-1:0]   init_addr;
`endif

  logic                accept;
  logic                finish;
  logic                op_we;
  logic [31:0]         op_addr;
  logic [DATA_W-1:0]   op_wdata;
  logic                in_range;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // With zero wait states the access happens on the accept edge, so it uses the live request.
  always_comb begin
    accept    = (state == IDLE) && req_valid;
    finish    = (WAIT_CYCLES == 0) ? accept : ((state == WAIT) && (cnt == 4'd0));
    op_we     = (WAIT_CYCLES == 0) ? req_we    : lat_we;
    op_addr   = (WAIT_CYCLES == 0) ? req_addr  : lat_addr;
    op_wdata  = (WAIT_CYCLES == 0) ? req_wdata : lat_wdata;
    in_range  = (op_addr[31:ADDR_W] == '0);
    mem_wr    = rst_n && finish && op_we && in_range;
    mem_waddr = op_addr[ADDR_W-1:0];
    mem_wdata = op_wdata;
`ifdef DMEM_ZERO_INIT_EN
    if (state == INIT) begin
      mem_wr    = rst_n;
      mem_waddr = init_addr;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef DMEM_ZERO_INIT_EN
      state     <= INIT;
      req_ready <= 1'b0;
      init_addr <= '0;
`else
      state     <= IDLE;
      req_ready <= 1'b1;
`endif
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= CNT_LOAD;
            req_ready <= 1'b0;
            state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
`ifdef DMEM_ZERO_INIT_EN
        INIT: begin
          if (&init_addr) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            init_addr <= init_addr + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase

      // Out-of-range addresses never touch the array and report an error instead.
      if (finish) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        if (!in_range) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end else if (op_we) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end else begin
          rsp_rdata <= mem[op_addr[ADDR_W-1:0]];
          rsp_err   <= 1'b0;
        end
      end
    end
  end

endmodule
